reducer_row_resolver: RTL

- Consumes the three rows produced by the 7:3 column reducer and resolves them into one binary sum.
- Rows are s (weight 2^i), c1 (bit i has weight 2^i, so bit 0 is always 0), and c2 (bit i has weight 2^i, so bits 1:0 are always 0).
- The final carry-propagate step runs iteratively, CHUNK bits per clock, to keep the adder small.
- Sits between the reducer and the multiplier/ALU result register, with valid/ready handshakes on both sides.

---
 rtl/reducer_row_resolver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reducer_row_resolver.sv
// ---------------------------------------------------------------------------
// reducer_row_resolver
//
// Purpose:
//   Takes the three rows left by the 7:3 column reducer (sum row s, single-
//   carry row c1, double-carry row c2, all already weight-aligned) and
//   resolves them into one exact 35-bit binary sum. The carry-propagate add
//   is done CHUNK bits per clock so only a small (CHUNK+2)-bit adder is
//   needed; an operation takes NPASS = ceil(35/CHUNK) add cycles.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream presents a row set
//   in_ready   high only while idle; a row set is taken on in_valid&&in_ready
//   in_s       sum row (weight 2^i)
//   in_c1      single-carry row, bit 0 is zero for legal rows
//   in_c2      double-carry row, bits 1:0 are zero for legal rows
//   out_valid  result is presented and held until accepted
//   out_ready  downstream accepts the result
//   out_sum    in_s + in_c1 + in_c2
//   busy       high while an operation is in flight (adding or presenting)
// ---------------------------------------------------------------------------
module reducer_row_resolver #(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_s,
    input  logic [32:0] in_c1,
    input  logic [33:0] in_c2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [34:0] out_sum,
    output logic        busy
);

    localparam int NPASS = (35 + CHUNK - 1) / CHUNK;
    localparam int W     = NPASS * CHUNK;
    localparam int KW    = (NPASS > 1) ? $clog2(NPASS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [CHUNK-1:0] s_q   [NPASS];
    logic [CHUNK-1:0] c1_q  [NPASS];
    logic [CHUNK-1:0] c2_q  [NPASS];
    logic [CHUNK-1:0] res_q [NPASS];
    logic [1:0]       carry;
    logic [KW-1:0]    pass;

    logic [W-1:0]     s_pad;
    logic [W-1:0]     c1_pad;
    logic [W-1:0]     c2_pad;
    logic [CHUNK+1:0] t;
    logic [CHUNK-1:0] res_next [NPASS];
    logic [W-1:0]     res_flat;

    // The rows are zero-extended to a whole number of chunks so that every
    // pass sees a full CHUNK-wide slice of each row.
    assign s_pad  = {{(W-32){1'b0}}, in_s};
    assign c1_pad = {{(W-33){1'b0}}, in_c1};
    assign c2_pad = {{(W-34){1'b0}}, in_c2};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // The latched rows are kept as arrays of chunks that shift down by one
    // chunk per pass, so the adder always works on entry 0 and no variable
    // part-select is needed. Three CHUNK-bit operands plus a carry of at most
    // 2 can never exceed CHUNK+2 bits, so the 2-bit carry is always enough.
    // The result array shifts down the same way, taking the new chunk at the
    // top, so after NPASS passes chunk 0 has arrived at entry 0.
    always_comb begin
        t = {2'b00, s_q[0]} + {2'b00, c1_q[0]} + {2'b00, c2_q[0]}
            + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < NPASS; i++) begin
            res_next[i] = '0;
        end
        for (int i = 0; i < NPASS - 1; i++) begin
            res_next[i] = res_q[i+1];
        end
        res_next[NPASS-1] = t[CHUNK-1:0];
        res_flat = '0;
        for (int i = 0; i < NPASS; i++) begin
            res_flat[i*CHUNK +: CHUNK] = res_next[i];
        end
    end

    // The padding bits above bit 34 are always zero for legal reducer rows
    // because the largest possible sum fits in 35 bits; they are dropped.
    if (W > 35) begin : g_pad
        logic unused_pad;
        assign unused_pad = |res_flat[W-1:35];
    end

    // Control FSM. IDLE latches a row set, ADD resolves one chunk per cycle
    // with the carry rippling from pass to pass, DONE presents the result
    // until the downstream handshake. out_sum is only written on entry to
    // DONE so it keeps its previous value while a new sum is accumulating.
    // A reset anywhere discards the in-flight work. The data arrays need no
    // reset because they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            pass      <= '0;
            carry     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NPASS; i++) begin
                            s_q[i]  <= s_pad[i*CHUNK +: CHUNK];
                            c1_q[i] <= c1_pad[i*CHUNK +: CHUNK];
                            c2_q[i] <= c2_pad[i*CHUNK +: CHUNK];
                        end
                        carry <= '0;
                        pass  <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NPASS - 1; i++) begin
                        s_q[i]  <= s_q[i+1];
                        c1_q[i] <= c1_q[i+1];
                        c2_q[i] <= c2_q[i+1];
                    end
                    s_q[NPASS-1]  <= '0;
                    c1_q[NPASS-1] <= '0;
                    c2_q[NPASS-1] <= '0;
                    for (int i = 0; i < NPASS; i++) begin
                        res_q[i] <= res_next[i];
                    end
                    carry <= t[CHUNK+1:CHUNK];
                    if (pass == KW'(NPASS - 1)) begin
                        out_sum   <= res_flat[34:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        pass <= pass + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
